// File: rtl/cpu_mem_if.sv
// Request/acknowledge bus between the 301 CPU address/data mux and the memory responder.
interface cpu_mem_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;
    logic              busy;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output rdata, ack, busy, err
    );
endinterface

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 301 CPU bus: captures a request, waits WAIT_CYCLES, commits and pulses ack.
// Optional macro CPU_MEM_ADDR_CHECK_EN flags out-of-range addresses on err instead of aliasing them.
module cpu_mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic       clk,
    input logic       reset,
    cpu_mem_if.slave  bus
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_ack;
    logic              r_busy;
    logic [DATA_W-1:0] r_mem [MEM_DEPTH];

    logic              w_capture;
    logic              w_commit;
    logic              w_cmtWe;
    logic [IDX_W-1:0]  w_cmtIdx;
    logic [DATA_W-1:0] w_cmtData;
    logic              w_memWe;

`ifdef CPU_MEM_ADDR_CHECK_EN
    logic r_oor;
    logic r_err;
    logic w_inOor;
    logic w_cmtOor;

    assign w_inOor = ({1'b0, bus.addr} >= (ADDR_W+1)'(MEM_DEPTH));
`endif

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    w_capture = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_next   = S_RESP;
                        w_commit = 1'b1;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next   = S_RESP;
                    w_commit = 1'b1;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase

        // With zero wait states the commit happens on the capture edge, so use the live bus.
        w_cmtWe   = w_capture ? bus.we : r_we;
        w_cmtIdx  = w_capture ? bus.addr[IDX_W-1:0] : r_idx;
        w_cmtData = w_capture ? bus.wdata : r_wdata;
`ifdef CPU_MEM_ADDR_CHECK_EN
        w_cmtOor  = w_capture ? w_inOor : r_oor;
        w_memWe   = reset && w_commit && w_cmtWe && !w_cmtOor;
`else
        w_memWe   = reset && w_commit && w_cmtWe;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
`ifdef CPU_MEM_ADDR_CHECK_EN
            r_oor   <= 1'b0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_ack   <= (w_next == S_RESP);

            if (w_capture) begin
                r_we    <= bus.we;
                r_idx   <= bus.addr[IDX_W-1:0];
                r_wdata <= bus.wdata;
                r_cnt   <= 4'(WAIT_CYCLES);
`ifdef CPU_MEM_ADDR_CHECK_EN
                r_oor   <= w_inOor;
`endif
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

`ifdef CPU_MEM_ADDR_CHECK_EN
            if (w_commit) begin
                r_err <= w_cmtOor;
                if (w_cmtOor) begin
                    r_rdata <= '0;
                end else if (!w_cmtWe) begin
                    r_rdata <= r_mem[w_cmtIdx];
                end
            end else if (w_capture) begin
                r_err <= 1'b0;
            end
`else
            if (w_commit && !w_cmtWe) begin
                r_rdata <= r_mem[w_cmtIdx];
            end
`endif
        end
    end

    // The word array has no reset; reset only gates a commit that would otherwise land during it.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[w_cmtIdx] <= w_cmtData;
        end
    end

    assign bus.rdata = r_rdata;
    assign bus.ack   = r_ack;
    assign bus.busy  = r_busy;
`ifdef CPU_MEM_ADDR_CHECK_EN
    assign bus.err   = r_err;
`else
    assign bus.err   = 1'b0;
`endif
endmodule

// File: tb/tb_cpu_mem_responder.sv
// Scoreboard bench for cpu_mem_responder: directed requests push expectations, a monitor checks every ack.
module tb_cpu_mem_responder;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cpu_mem_if #(.ADDR_W(16), .DATA_W(16)) bus();

    cpu_mem_responder #(
        .ADDR_W(16),
        .DATA_W(16),
        .MEM_DEPTH(256),
        .WAIT_CYCLES(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Edges from the capture edge to the edge entering RESP (ack visible in the third cycle).
    localparam int ACK_OFFSET = 2;

`ifdef CPU_MEM_ADDR_CHECK_EN
    localparam logic        ALIAS_ERR = 1'b1;
    localparam logic [15:0] ALIAS_RD  = 16'hA5C3;
`else
    localparam logic        ALIAS_ERR = 1'b0;
    localparam logic [15:0] ALIAS_RD  = 16'h7777;
`endif

    typedef struct {
        logic [15:0] rdata;
        logic        err;
        int          cap;
    } exp_t;

    exp_t expQ[$];
    int   nChecks = 0;
    int   nFail   = 0;
    int   cyc     = 0;
    logic prevAck = 1'b0;
    int   t1;
    int   t2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Monitor: every ack pops one expectation and checks data, err, latency and pulse width.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (bus.ack) begin
                checkOutput("ackSingleCycle", {31'd0, prevAck}, 32'd0);
                if (expQ.size() == 0) begin
                    nChecks++;
                    nFail++;
                    $display("[TB] FAIL unexpectedAck: got ack=1, expected no ack (t=%0t)", $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("ackRdata", {16'd0, bus.rdata}, {16'd0, e.rdata});
                    checkOutput("ackErr", {31'd0, bus.err}, {31'd0, e.err});
                    checkOutput("ackLatency", cyc - e.cap, ACK_OFFSET);
                end
            end
            prevAck = bus.ack;
        end else begin
            prevAck = 1'b0;
        end
    end

    // Called at a negedge; returns at the negedge where ack is seen (or after the bound expires).
    task automatic applyStimulus(input logic iWe, input logic [15:0] iAddr, input logic [15:0] iWdata,
                                 input logic [15:0] expRdata, input logic expErr,
                                 input int edgesToCapture, input bit holdReq, input bit disturb);
        exp_t e;
        bit   found;
        bus.req   = 1'b1;
        bus.we    = iWe;
        bus.addr  = iAddr;
        bus.wdata = iWdata;
        repeat (edgesToCapture) @(posedge clk);
        #1;
        e.rdata = expRdata;
        e.err   = expErr;
        e.cap   = cyc;
        expQ.push_back(e);
        checkOutput("busyAfterCapture", {31'd0, bus.busy}, 32'd1);
        @(negedge clk);
        if (!holdReq) bus.req = 1'b0;
        if (disturb) begin
            bus.we    = 1'b1;
            bus.addr  = iAddr + 16'd1;
            bus.wdata = 16'hDEAD;
        end
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.ack) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) checkOutput("ackTimeout", 32'd0, 32'd1);
    endtask

    task automatic idleCycles(input int n);
        bus.req = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b0;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetRdata", {16'd0, bus.rdata}, 32'd0);
        checkOutput("resetAck",   {31'd0, bus.ack},   32'd0);
        checkOutput("resetBusy",  {31'd0, bus.busy},  32'd0);
        checkOutput("resetErr",   {31'd0, bus.err},   32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Write then read back; rdata must hold across idle cycles.
        applyStimulus(1'b1, 16'h0010, 16'hA5C3, 16'h0000, 1'b0, 1, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 16'h0010, 16'h0000, 16'hA5C3, 1'b0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("rdataHold", {16'd0, bus.rdata}, 32'h0000A5C3);
        end

        // Held req: second capture happens after one IDLE cycle.
        applyStimulus(1'b1, 16'h0020, 16'h0001, 16'hA5C3, 1'b0, 1, 1'b1, 1'b0);
        t1 = cyc;
        applyStimulus(1'b0, 16'h0020, 16'h0000, 16'h0001, 1'b0, 2, 1'b0, 1'b0);
        t2 = cyc;
        checkOutput("b2bAckGap", t2 - t1, 32'd4);
        idleCycles(2);

        // Preload locations, then change inputs during WAIT of a read.
        applyStimulus(1'b1, 16'h0030, 16'h1234, 16'h0001, 1'b0, 1, 1'b0, 1'b0);
        idleCycles(1);
        applyStimulus(1'b1, 16'h0031, 16'h5555, 16'h0001, 1'b0, 1, 1'b0, 1'b0);
        idleCycles(1);
        applyStimulus(1'b1, 16'h0040, 16'h0000, 16'h0001, 1'b0, 1, 1'b0, 1'b0);
        idleCycles(1);
        applyStimulus(1'b0, 16'h0030, 16'h0000, 16'h1234, 1'b0, 1, 1'b0, 1'b1);
        idleCycles(1);
        applyStimulus(1'b0, 16'h0031, 16'h0000, 16'h5555, 1'b0, 1, 1'b0, 1'b0);
        idleCycles(1);

        // Reset during the WAIT of a write: no ack, no commit.
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 16'h0040;
        bus.wdata = 16'hBEEF;
        @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        bus.req = 1'b0;
        #1;
        checkOutput("abortBusy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abortAck",  {31'd0, bus.ack},  32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abortNoAck", {31'd0, bus.ack}, 32'd0);
        end
        reset = 1'b1;
        idleCycles(2);
        applyStimulus(1'b0, 16'h0040, 16'h0000, 16'h0000, 1'b0, 1, 1'b0, 1'b0);
        idleCycles(1);

        // Upper address bits: alias into mem[0x10] or flag as out of range.
        applyStimulus(1'b1, 16'h0110, 16'h7777, 16'h0000, ALIAS_ERR, 1, 1'b0, 1'b0);
        idleCycles(1);
        applyStimulus(1'b0, 16'h0010, 16'h0000, ALIAS_RD, 1'b0, 1, 1'b0, 1'b0);
        idleCycles(3);

        checkOutput("scoreboardDrained", expQ.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the 301 16-bit RISC processor bus.
- Serves single-word read and write requests issued by the control unit / execution unit through a req/ack handshake.
- Inserts a programmable number of wait states and holds the backing word array.
- Sits between the CPU datapath address/data mux and the on-chip RAM. The CU holds req until it sees ack.

Parameters:
- ADDR_W, 16, width of the CPU address bus.
- DATA_W, 16, word width.
- MEM_DEPTH, 256, number of words. Must be a power of two and no larger than 2^ADDR_W.
- WAIT_CYCLES, 2, wait states inserted between request capture and ack (0..15 legal).

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  access request (level), sampled only in IDLE.
- we  input  1  1 = write, 0 = read; captured with req.
- addr  input  ADDR_W  word address; captured with req.
- wdata  input  DATA_W  write data; captured with req.
- rdata  output  DATA_W  registered read data.
- ack  output  1  one-cycle completion pulse.
- busy  output  1  high whenever state is not IDLE.
- err  output  1  address-range error flag (ADDR_CHECK_EN only, else tied 0).

Behaviour:
- Reset values (reset low, asynchronous):
  - state = IDLE, wait counter = 0, capture registers = 0.
  - rdata = 0, ack = 0, busy = 0, err = 0.
  - Memory array is NOT cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a clk edge with req=1, capture we, addr and wdata, and load counter = WAIT_CYCLES.
  - If WAIT_CYCLES > 0, next state = WAIT. If WAIT_CYCLES = 0, next state = RESP.
  - req=0 keeps the block in IDLE.
- WAIT:
  - Counter decrements by 1 each edge.
  - When counter = 1 at an edge, next state = RESP.
  - req, we, addr and wdata are ignored while in WAIT (captured copies are used).
- Access commit, on the edge entering RESP:
  - Write: mem[idx] <= captured wdata. rdata is unchanged.
  - Read: rdata <= mem[idx].
  - idx = captured addr[log2(MEM_DEPTH)-1:0]. Upper address bits alias.
- RESP:
  - ack = 1 for exactly this one cycle, then next state = IDLE unconditionally.
  - A req still high during RESP is ignored.
- Latency: ack asserts WAIT_CYCLES+1 cycles after the req capture edge.
  - Example: WAIT_CYCLES=2 gives capture edge, then 2 WAIT cycles, then the RESP cycle.
  - Back-to-back requests cost one IDLE cycle between acks.
- rdata holds the last read value until the next read commit. Writes never disturb it.
- busy = (state != IDLE), a registered decode of state.
- Reset asserted mid-operation:
  - Aborts the transaction immediately.
  - A write not yet committed (still in WAIT) is lost; memory is untouched.
  - No ack is produced.
- Read of a never-written location returns X in simulation. The bench must initialise memory first.

Optional Feature:
- Macro: CPU_MEM_ADDR_CHECK_EN.
- Defined:
  - A captured addr >= MEM_DEPTH is an out-of-range access.
  - At the RESP entry edge: err <= 1, no write is performed, rdata <= 0, and ack pulses as usual.
  - err is cleared at the next req capture.
- Undefined:
  - err is constant 0.
  - Upper address bits are ignored and accesses alias modulo MEM_DEPTH.

Test Plan:
- Reset then write: release reset, req=1, we=1, addr=0x0010, wdata=0xA5C3 -> busy high next cycle, ack high exactly 3 cycles after the capture edge, single cycle, rdata stays 0x0000.
- Read-back: after the write, req=1, we=0, addr=0x0010 -> ack after 3 cycles with rdata=0xA5C3, held through the following 5 idle cycles.
- Held req / back-to-back: req held high for two transactions, write 0x0001 to addr 0x20 then read addr 0x20 -> two ack pulses separated by exactly one IDLE cycle, second ack with rdata=0x0001.
- Input change during WAIT: capture a read of addr 0x30 (mem=0x1234), then switch addr to 0x31 and we to 1 during WAIT -> rdata=0x1234, mem[0x31] unchanged.
- Reset mid-write: capture a write of 0xBEEF to addr 0x40 (mem=0x0000), pull reset low during WAIT -> ack never asserts, busy=0, a later read of 0x40 returns 0x0000.
- Feature: with CPU_MEM_ADDR_CHECK_EN, write to addr 0x0110 with MEM_DEPTH=256 -> err=1 at ack, mem[0x10] unchanged. Without the macro, the same write lands in mem[0x10] and err=0.
